// File: rtl/pc_exception_unit_if.sv
// pc_exception_unit_if: controller/datapath-facing signal bundle of the PC and exception unit.
interface pc_exception_unit_if #(parameter int CNT_W = 8);
  logic             PCWrite;
  logic             PCWriteCond;
  logic             Zero;
  logic [2:0]       PCSource;
  logic [31:0]      ALUResult;
  logic [31:0]      ALUOut;
  logic [25:0]      JumpField;
  logic [31:0]      RegA;
  logic [4:0]       RdField;
  logic             EPCWrite;
  logic             ErrorTargetWrite;
  logic [31:0]      PC;
  logic [31:0]      EPC;
  logic [4:0]       ErrorTarget;
  logic             InHandler;
  logic [CNT_W-1:0] ExcCount;
  logic             NestErr;
  logic             AlignErr;
  modport master (
    output PCWrite, PCWriteCond, Zero, PCSource, ALUResult, ALUOut, JumpField, RegA,
           RdField, EPCWrite, ErrorTargetWrite,
    input  PC, EPC, ErrorTarget, InHandler, ExcCount, NestErr, AlignErr
  );
  modport slave (
    input  PCWrite, PCWriteCond, Zero, PCSource, ALUResult, ALUOut, JumpField, RegA,
           RdField, EPCWrite, ErrorTargetWrite,
    output PC, EPC, ErrorTarget, InHandler, ExcCount, NestErr, AlignErr
  );
endinterface

// File: rtl/pc_exception_unit.sv
// pc_exception_unit: PC register, next-PC selection and overflow exception state of the multi-cycle CPU.
module pc_exception_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter int          CNT_W        = 8
) (
  input logic                clk,
  input logic                reset,
  pc_exception_unit_if.slave bus
);
  logic [31:0]      pc_q, pc_d, epc_q, epc_d, target;
  logic [4:0]       et_q, et_d;
  logic             ih_q, ih_d, nest_q, nest_d, align_q, align_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr, ret;
  always_comb begin
    target  = bus.PCSource == 3'b000 ? bus.ALUResult :
              bus.PCSource == 3'b001 ? bus.ALUOut :
              bus.PCSource == 3'b010 ? {pc_q[31:28], bus.JumpField, 2'b00} :
              bus.PCSource == 3'b011 ? bus.RegA :
              bus.PCSource == 3'b100 ? HANDLER_ADDR :
              bus.PCSource == 3'b101 ? epc_q : pc_q;
    // 110/111 select "hold", so they never count as a write
    wr      = (bus.PCWrite | (bus.PCWriteCond & bus.Zero)) & ~(bus.PCSource[2] & bus.PCSource[1]);
    ret     = wr & (bus.PCSource == 3'b101);
    pc_d    = wr ? {target[31:2], 2'b00} : pc_q;
    align_d = align_q | (wr & |target[1:0]);
    epc_d   = bus.EPCWrite & ~ih_q ? pc_q : epc_q;
    et_d    = bus.ErrorTargetWrite & ~ih_q ? bus.RdField : et_q;
    ih_d    = bus.EPCWrite ? 1'b1 : ret ? 1'b0 : ih_q;
    nest_d  = nest_q | (bus.EPCWrite & ih_q);
    cnt_d   = bus.EPCWrite & ~&cnt_q ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      et_q    <= '0;
      ih_q    <= 1'b0;
      nest_q  <= 1'b0;
      align_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      et_q    <= et_d;
      ih_q    <= ih_d;
      nest_q  <= nest_d;
      align_q <= align_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.PC          = pc_q;
  assign bus.EPC         = epc_q;
  assign bus.ErrorTarget = et_q;
  assign bus.InHandler   = ih_q;
  assign bus.ExcCount    = cnt_q;
  assign bus.NestErr     = nest_q;
  assign bus.AlignErr    = align_q;
endmodule

// File: tb/tb_pc_exception_unit.sv
// tb_pc_exception_unit: directed test-plan sequences plus randomized traffic against a reference model.
module tb_pc_exception_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0, bad = 0;
  logic [31:0] m_pc, m_epc;
  logic [4:0]  m_et;
  logic        m_ih, m_nest, m_al;
  int          m_cnt;
  always #5 clk = ~clk;
  pc_exception_unit_if #(.CNT_W(8)) bus ();
  pc_exception_unit #(.RESET_PC(32'h0), .HANDLER_ADDR(32'h80), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.PCWrite = 0; bus.PCWriteCond = 0; bus.Zero = 0; bus.PCSource = 3'b110;
    bus.ALUResult = 0; bus.ALUOut = 0; bus.JumpField = 0; bus.RegA = 0;
    bus.RdField = 0; bus.EPCWrite = 0; bus.ErrorTargetWrite = 0;
  endtask
  task automatic model();
    logic [31:0] tgt, old_pc;
    logic        we, old_ih;
    if (reset) begin
      m_pc = 0; m_epc = 0; m_et = 0; m_ih = 0; m_nest = 0; m_al = 0; m_cnt = 0;
      return;
    end
    old_pc = m_pc;
    old_ih = m_ih;
    case (bus.PCSource)
      3'd0: tgt = bus.ALUResult;
      3'd1: tgt = bus.ALUOut;
      3'd2: tgt = (old_pc & 32'hF000_0000) | ({6'b0, bus.JumpField} * 4);
      3'd3: tgt = bus.RegA;
      3'd4: tgt = 32'h80;
      3'd5: tgt = m_epc;
      default: tgt = old_pc;
    endcase
    we = (bus.PCWrite || (bus.PCWriteCond && bus.Zero)) && bus.PCSource < 6;
    if (we) begin
      m_pc = tgt - (tgt % 4);
      if (tgt % 4 != 0) m_al = 1;
    end
    if (bus.ErrorTargetWrite && !old_ih) m_et = bus.RdField;
    if (bus.EPCWrite) begin
      if (old_ih) m_nest = 1;
      else m_epc = old_pc;
      if (m_cnt < 255) m_cnt++;
      m_ih = 1;
    end else if (we && bus.PCSource == 5) m_ih = 0;
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("pc", bus.PC, m_pc);
    chk("epc", bus.EPC, m_epc);
    chk("et", 32'(bus.ErrorTarget), 32'(m_et));
    chk("ih", 32'(bus.InHandler), 32'(m_ih));
    chk("cnt", 32'(bus.ExcCount), 32'(m_cnt));
    chk("nest", 32'(bus.NestErr), 32'(m_nest));
    chk("align", 32'(bus.AlignErr), 32'(m_al));
  endtask
  task automatic set_pc(input logic [31:0] v);
    idle(); bus.PCWrite = 1; bus.PCSource = 0; bus.ALUResult = v;
    step();
  endtask
  initial begin
    logic [31:0] r;
    idle();
    reset = 1;
    step();
    chk("rst_pc", bus.PC, 32'h0);
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      set_pc(32'(4 * i));
      chk("seq_pc", bus.PC, 32'(4 * i));
    end
    set_pc(32'h10);
    idle(); bus.PCWriteCond = 1; bus.PCSource = 1; bus.ALUOut = 32'h40; bus.Zero = 0;
    step();
    chk("cond_nz", bus.PC, 32'h10);
    bus.Zero = 1;
    step();
    chk("cond_z", bus.PC, 32'h40);
    set_pc(32'h8000_0010);
    idle(); bus.PCWrite = 1; bus.PCSource = 2; bus.JumpField = 26'h20;
    step();
    chk("jump", bus.PC, 32'h8000_0080);
    idle(); bus.PCWrite = 1; bus.PCSource = 3; bus.RegA = 32'h123;
    step();
    chk("jr_pc", bus.PC, 32'h120);
    chk("jr_align", 32'(bus.AlignErr), 1);
    set_pc(32'h24);
    idle(); bus.PCWrite = 1; bus.PCSource = 4; bus.EPCWrite = 1; bus.ErrorTargetWrite = 1; bus.RdField = 9;
    step();
    chk("ent_epc", bus.EPC, 32'h24);
    chk("ent_et", 32'(bus.ErrorTarget), 9);
    chk("ent_ih", 32'(bus.InHandler), 1);
    chk("ent_cnt", 32'(bus.ExcCount), 1);
    chk("ent_pc", bus.PC, 32'h80);
    idle(); bus.PCWrite = 1; bus.PCSource = 5;
    step();
    chk("ret_pc", bus.PC, 32'h24);
    chk("ret_ih", 32'(bus.InHandler), 0);
    idle(); bus.PCWrite = 1; bus.PCSource = 4; bus.EPCWrite = 1; bus.ErrorTargetWrite = 1; bus.RdField = 9;
    step();
    set_pc(32'h90);
    idle(); bus.EPCWrite = 1; bus.ErrorTargetWrite = 1; bus.RdField = 3;
    step();
    chk("nest_epc", bus.EPC, 32'h24);
    chk("nest_et", 32'(bus.ErrorTarget), 9);
    chk("nest_flag", 32'(bus.NestErr), 1);
    chk("nest_cnt", 32'(bus.ExcCount), 3);
    idle(); bus.EPCWrite = 1;
    for (int i = 0; i < 260; i++) step();
    chk("sat_cnt", 32'(bus.ExcCount), 255);
    idle(); reset = 1; bus.PCWrite = 1; bus.PCSource = 0; bus.ALUResult = 32'h44;
    bus.EPCWrite = 1; bus.ErrorTargetWrite = 1; bus.RdField = 7;
    step();
    reset = 0; idle();
    chk("mid_pc", bus.PC, 32'h0);
    chk("mid_epc", bus.EPC, 32'h0);
    chk("mid_cnt", 32'(bus.ExcCount), 0);
    chk("mid_ih", 32'(bus.InHandler), 0);
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.PCWrite = ($urandom_range(0, 2) == 0);
      bus.PCWriteCond = $urandom_range(0, 1);
      bus.Zero = $urandom_range(0, 1);
      bus.PCSource = 3'($urandom_range(0, 7));
      r = $urandom();
      bus.ALUResult = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
      r = $urandom();
      bus.ALUOut = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
      r = $urandom();
      bus.RegA = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
      bus.JumpField = 26'($urandom());
      bus.RdField = 5'($urandom());
      bus.EPCWrite = ($urandom_range(0, 7) == 0);
      bus.ErrorTargetWrite = ($urandom_range(0, 3) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
